// File: rtl/uart_pm_loader_if.sv
// uart_pm_loader_if: program-memory write bus (pm_address, pm_data, pm_we); master drives, slave receives
interface uart_pm_loader_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] pm_address;
  logic [15:0] pm_data;
  logic pm_we;
  modport master (output pm_address, pm_data, pm_we);
  modport slave (input pm_address, pm_data, pm_we);
endinterface

// File: rtl/uart_pm_loader.sv
// uart_pm_loader: UART 8N1 bootloader filling program memory; ports clock, reset, rx, pm (write bus), core_reset, busy, done, error
module uart_pm_loader #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD = 230400,
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 2_500_000
) (
  input logic clock,
  input logic reset,
  input logic rx,
  uart_pm_loader_if.master pm,
  output logic core_reset,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CSUM} st_t;
  logic s1, s2;
  rx_t rs, rs_n;
  logic [CW-1:0] cnt;
  logic [2:0] bidx;
  logic [7:0] sh;
  logic tick_half, tick_bit, rx_valid, rx_ferr;
  st_t st, st_n;
  logic [15:0] rem, data;
  logic [7:0] lo, sum;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0] tcnt;
  logic we, tout, abort;
  always_comb begin
    tick_half = cnt == CW'(HALF - 1);
    tick_bit = cnt == CW'(DIV - 1);
    rs_n = rs == RX_IDLE ? (s2 ? RX_IDLE : RX_START)
      : rs == RX_START ? (!tick_half ? RX_START : s2 ? RX_IDLE : RX_DATA)
      : rs == RX_DATA ? (tick_bit && bidx == 3'd7 ? RX_STOP : RX_DATA)
      : (tick_bit ? RX_IDLE : RX_STOP);
    rx_valid = rs == RX_STOP && tick_bit && s2;
    rx_ferr = rs == RX_STOP && tick_bit && !s2;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rs <= RX_IDLE;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      rs <= rs_n;
      cnt <= (rs == RX_IDLE || rs != rs_n || tick_bit) ? '0 : cnt + 1'b1;
      if (rs == RX_START) bidx <= '0;
      if (rs == RX_DATA && tick_bit) begin
        sh <= {s2, sh[7:1]};
        bidx <= bidx + 1'b1;
      end
    end
  end
  always_comb begin
    tout = st != IDLE && !rx_valid && tcnt == TW'(TIMEOUT - 1);
    abort = st != IDLE && (rx_ferr || tout);
    st_n = abort ? IDLE
      : !rx_valid ? st
      : st == IDLE ? (sh == 8'h55 ? LEN_LO : IDLE)
      : st == LEN_LO ? LEN_HI
      : st == LEN_HI ? ({sh, rem[7:0]} == 16'd0 ? CSUM : DAT_LO)
      : st == DAT_LO ? DAT_HI
      : st == DAT_HI ? (rem == 16'd1 ? CSUM : DAT_LO)
      : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      rem <= '0;
      lo <= '0;
      sum <= '0;
      addr <= '0;
      tcnt <= '0;
      data <= '0;
      we <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      st <= st_n;
      we <= 1'b0;
      done <= 1'b0;
      tcnt <= (st == IDLE || rx_valid) ? '0 : tcnt + 1'b1;
      // address advances the cycle after the strobe so it is stable while pm_we is high
      if (we) addr <= addr + 1'b1;
      if (abort) error <= 1'b1;
      else if (rx_valid)
        case (st)
          IDLE: if (sh == 8'h55) begin
            error <= 1'b0;
            addr <= '0;
            sum <= '0;
          end
          LEN_LO: rem[7:0] <= sh;
          LEN_HI: rem[15:8] <= sh;
          DAT_LO: begin
            lo <= sh;
            sum <= sum + sh;
          end
          DAT_HI: begin
            we <= 1'b1;
            data <= {sh, lo};
            sum <= sum + sh;
            rem <= rem - 1'b1;
          end
          CSUM: begin
            done <= sh == sum;
            error <= sh != sum;
          end
          default: ;
        endcase
    end
  end
  assign busy = st != IDLE;
  assign core_reset = busy;
  assign pm.pm_we = we;
  assign pm.pm_address = addr;
  assign pm.pm_data = data;
endmodule
